dp_scale_avg: RTL and testbench

Parametrised multi-channel fixed-point scaler with per-channel block averaging, used between the I2C sensor readout and the TM1638 display formatter. Each raw sample is multiplied by a runtime coefficient, rounded, shifted by a fixed fraction width and saturated. 2^AVG_LOG2 scaled samples are then averaged per channel before output. A valid/ready handshake with full-pipeline stall carries a channel tag; the default configuration reproduces the lux conversion raw·425/512.

---
 rtl/dp_pkg.sv | 21 ++
 rtl/dp_scale_avg_if.sv | 28 ++
 rtl/dp_avg_acc.sv | 71 +++++++
 rtl/dp_scale_avg.sv | 97 +++++++++
 tb/tb_dp_scale_avg.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared constants and width helpers for the fixed-point scale/average datapath.
// The lux constants reproduce raw*425/512.
package dp_pkg;

    localparam int DP_LUX_COEF = 425;
    localparam int DP_LUX_FRAC = 9;

    function automatic int ch_width(int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Half an LSB of the result, added before the fraction bits are dropped.
    function automatic logic [63:0] round_const(int frac);
        return 64'd1 << (frac - 1);
    endfunction

    function automatic logic [63:0] sat_max(int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/dp_scale_avg_if.sv
// Sample stream in, averaged result stream out, each with a valid/ready pair.
interface dp_scale_avg_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int COEF_W = 10,
    parameter int CH_W   = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [IN_W-1:0]   in_data;
    logic [COEF_W-1:0] coef;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    modport master (
        output in_valid, in_ch, in_data, coef, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_ch, in_data, coef, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_sat
    );
endinterface

// File: rtl/dp_avg_acc.sv
// Per-channel block accumulator: sums 2^AVG_LOG2 scaled samples per channel and
// emits the truncated mean with a sticky saturation flag through the output register.
module dp_avg_acc
    import dp_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int OUT_W    = 16,
    parameter int AVG_LOG2 = 2,
    parameter int CH_W     = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [OUT_W-1:0] in_s,
    input  logic             in_sat,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);
    localparam int SUM_W = OUT_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [SUM_W-1:0] sum_q [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [NCH-1:0]   sticky_q;
    logic [SUM_W-1:0] sum_nx;
    logic             last;
    logic             sticky_nx;

    assign sum_nx    = sum_q[in_ch] + SUM_W'(in_s);
    assign last      = (cnt_q[in_ch] == CNT_LAST);
    assign sticky_nx = sticky_q[in_ch] | in_sat;

    // NOTE: the bank is reset explicitly; a partial window must never survive a reset.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            sticky_q  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (adv && in_valid) begin
                if (last) begin
                    sum_q[in_ch]    <= '0;
                    cnt_q[in_ch]    <= '0;
                    sticky_q[in_ch] <= 1'b0;
                    out_data        <= OUT_W'(sum_nx >> AVG_LOG2);
                    out_sat         <= sticky_nx;
                    out_ch          <= in_ch;
                    out_valid       <= 1'b1;
                end else begin
                    sum_q[in_ch]    <= sum_nx;
                    cnt_q[in_ch]    <= cnt_q[in_ch] + 1'b1;
                    sticky_q[in_ch] <= sticky_nx;
                end
            end
        end
    end

endmodule

// File: rtl/dp_scale_avg.sv
// Multi-channel fixed-point scaler: multiply, round, drop FRAC bits, saturate,
// then block-average per channel. Whole pipeline stalls on a blocked output.
module dp_scale_avg
    import dp_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int COEF_W   = 10,
    parameter int FRAC     = DP_LUX_FRAC,
    parameter int NCH      = 2,
    parameter int AVG_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    dp_scale_avg_if.slave bus
);
    localparam int CH_W  = ch_width(NCH);
    localparam int P_W   = IN_W + COEF_W;
    localparam int R_W   = P_W + 1 - FRAC;
    localparam int CMP_W = (R_W > OUT_W) ? R_W : OUT_W;

    logic              adv;
    logic              ch_ok;
    logic [P_W:0]      rounded_sum;
    logic              sat_hit;

    logic              s1_valid;
    logic [IN_W-1:0]   s1_data;
    logic [COEF_W-1:0] s1_coef;
    logic [CH_W-1:0]   s1_ch;
    logic              s2_valid;
    logic [R_W-1:0]    s2_r;
    logic [CH_W-1:0]   s2_ch;
    logic              s3_valid;
    logic [OUT_W-1:0]  s3_s;
    logic              s3_sat;
    logic [CH_W-1:0]   s3_ch;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign ch_ok        = ({1'b0, bus.in_ch} < (CH_W + 1)'(NCH));

    // One extra bit keeps the round-half-up addition exact before the shift.
    assign rounded_sum = (P_W + 1)'(s1_data) * (P_W + 1)'(s1_coef)
                       + (P_W + 1)'(round_const(FRAC));
    assign sat_hit     = CMP_W'(s2_r) > CMP_W'(sat_max(OUT_W));

    // NOTE: non-blocking assignments let each stage take the previous stage's old value on the same edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_coef  <= '0;
            s1_ch    <= '0;
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_ch    <= '0;
            s3_valid <= 1'b0;
            s3_s     <= '0;
            s3_sat   <= 1'b0;
            s3_ch    <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid && ch_ok;
            s1_data  <= bus.in_data;
            s1_coef  <= bus.coef;
            s1_ch    <= bus.in_ch;
            s2_valid <= s1_valid;
            s2_r     <= R_W'(rounded_sum >> FRAC);
            s2_ch    <= s1_ch;
            s3_valid <= s2_valid;
            s3_s     <= sat_hit ? OUT_W'(sat_max(OUT_W)) : OUT_W'(s2_r);
            s3_sat   <= sat_hit;
            s3_ch    <= s2_ch;
        end
    end

    dp_avg_acc #(
        .NCH      (NCH),
        .OUT_W    (OUT_W),
        .AVG_LOG2 (AVG_LOG2),
        .CH_W     (CH_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .in_valid  (s3_valid),
        .in_ch     (s3_ch),
        .in_s      (s3_s),
        .in_sat    (s3_sat),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_ch    (bus.out_ch),
        .out_data  (bus.out_data),
        .out_sat   (bus.out_sat)
    );

endmodule

// File: tb/tb_dp_scale_avg.sv
// Scoreboard bench for dp_scale_avg: one instance without averaging, one with
// 4-sample windows; directed vectors carry hand-computed results.
module tb_dp_scale_avg;
    import dp_pkg::*;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int COEF_W = 10;
    localparam int NCH    = 2;
    localparam int CH_W   = ch_width(NCH);

    typedef struct {
        int ch;
        int data;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q2[$];

    // {ch, in_data, coef, expected out_data, expected out_sat}
    int vec0 [8][5] = '{
        '{0, 1,     425,  1,     0},
        '{1, 65535, 425,  54399, 0},
        '{0, 65535, 1023, 65535, 1},
        '{1, 65535, 512,  65535, 0},
        '{0, 65535, 513,  65535, 1},
        '{1, 300,   425,  249,   0},
        '{0, 777,   512,  777,   0},
        '{1, 1234,  0,    0,     0}
    };
    int il_ch   [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int il_data [8] = '{1200, 12, 1200, 12, 1200, 12, 1201, 12};

    always #5 clk = ~clk;

    dp_scale_avg_if #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .CH_W(CH_W)) if0 ();
    dp_scale_avg_if #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .CH_W(CH_W)) if2 ();

    dp_scale_avg #(
        .IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W),
        .FRAC(DP_LUX_FRAC), .NCH(NCH), .AVG_LOG2(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    dp_scale_avg #(
        .IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W),
        .FRAC(DP_LUX_FRAC), .NCH(NCH), .AVG_LOG2(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avg0_valid"}, if0.out_valid, 0);
        check({tag, "_avg0_data"},  if0.out_data,  0);
        check({tag, "_avg0_ch"},    if0.out_ch,    0);
        check({tag, "_avg0_sat"},   if0.out_sat,   0);
        check({tag, "_avg0_ready"}, if0.in_ready,  1);
        check({tag, "_avg2_valid"}, if2.out_valid, 0);
        check({tag, "_avg2_data"},  if2.out_data,  0);
        check({tag, "_avg2_ch"},    if2.out_ch,    0);
        check({tag, "_avg2_sat"},   if2.out_sat,   0);
        check({tag, "_avg2_ready"}, if2.in_ready,  1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting falling edge.
    task automatic send(input int sel, input int ch, input int data, input int cf);
        int waited;
        waited = 0;
        if0.in_ch   = CH_W'(ch);
        if0.in_data = IN_W'(data);
        if0.coef    = COEF_W'(cf);
        if2.in_ch   = CH_W'(ch);
        if2.in_data = IN_W'(data);
        if2.coef    = COEF_W'(cf);
        if0.in_valid = (sel == 0);
        if2.in_valid = (sel == 2);
        #1;
        while (((sel == 0) ? !if0.in_ready : !if2.in_ready) && waited < 100) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, required acceptance", waited);
        end
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
        if2.in_valid = 1'b0;
    endtask

    task automatic push0(input int ch, input int data, input bit sat);
        q0.push_back('{ch: ch, data: data, sat: sat});
    endtask

    task automatic push2(input int ch, input int data, input bit sat);
        q2.push_back('{ch: ch, data: data, sat: sat});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_avg0_pending"}, q0.size(), 0);
        check({tag, "_avg2_pending"}, q2.size(), 0);
    endtask

    initial begin : mon0
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL avg0_unexpected: ch=%0d data=%0d sat=%0d, required no output",
                             if0.out_ch, if0.out_data, if0.out_sat);
                end else begin
                    e = q0.pop_front();
                    check("avg0_data", if0.out_data, e.data);
                    check("avg0_sat",  if0.out_sat,  e.sat);
                    check("avg0_ch",   if0.out_ch,   e.ch);
                end
            end
        end
    end

    initial begin : mon2
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (if2.out_valid === 1'b1 && if2.out_ready === 1'b1) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL avg2_unexpected: ch=%0d data=%0d sat=%0d, required no output",
                             if2.out_ch, if2.out_data, if2.out_sat);
                end else begin
                    e = q2.pop_front();
                    check("avg2_data", if2.out_data, e.data);
                    check("avg2_sat",  if2.out_sat,  e.sat);
                    check("avg2_ch",   if2.out_ch,   e.ch);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        if0.in_valid = 1'b0; if0.in_ch = '0; if0.in_data = '0; if0.coef = '0; if0.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_ch = '0; if2.in_data = '0; if2.coef = '0; if2.out_ready = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Lux conversion and its pipeline latency, no averaging.
        push0(0, 996, 1'b0);
        send(0, 0, 1200, DP_LUX_COEF);
        #1;
        check("lat_edge0", if0.out_valid, 0);
        repeat (2) begin
            @(posedge clk);
            #2;
            check("lat_edge1_2", if0.out_valid, 0);
        end
        @(posedge clk);
        #2;
        check("lat_edge3", if0.out_valid, 1);
        @(posedge clk);
        #1;

        // Rounding, saturation boundaries and per-sample coefficient changes.
        for (int i = 0; i < 8; i++) begin
            push0(vec0[i][0], vec0[i][3], bit'(vec0[i][4]));
            send(0, vec0[i][0], vec0[i][1], vec0[i][2]);
        end

        // Continuous stream with the consumer blocked for ten edges.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    push0(i % 2, 1000 + i, 1'b0);
                    send(0, i % 2, 1000 + i, 512);
                end
            end
            begin
                int hits;
                hits = 0;
                repeat (3) @(posedge clk);
                #1 if0.out_ready = 1'b0;
                repeat (9) begin
                    @(posedge clk);
                    #2;
                    if (if0.out_valid) begin
                        hits++;
                        check("stall_in_ready", if0.in_ready, 0);
                    end
                end
                check("stall_valid_seen", (hits > 0) ? 1 : 0, 1);
                @(posedge clk);
                #1 if0.out_ready = 1'b1;
            end
        join

        // Interleaved 4-sample windows on both channels.
        for (int i = 0; i < 8; i++) begin
            if (i == 6) push2(0, 996, 1'b0);
            if (i == 7) push2(1, 10, 1'b0);
            send(2, il_ch[i], il_data[i], DP_LUX_COEF);
        end

        // One saturated sample poisons the window, then the flag clears.
        send(2, 0, 65535, 1023);
        repeat (2) send(2, 0, 1200, DP_LUX_COEF);
        push2(0, 17130, 1'b1);
        send(2, 0, 1200, DP_LUX_COEF);
        repeat (3) send(2, 0, 1200, DP_LUX_COEF);
        push2(0, 996, 1'b0);
        send(2, 0, 1200, DP_LUX_COEF);
        send(2, 1, 65535, 1023);
        repeat (2) send(2, 1, 12, DP_LUX_COEF);
        push2(1, 16391, 1'b1);
        send(2, 1, 12, DP_LUX_COEF);
        drain("windows");

        // Reset in the middle of a window; only later samples may count.
        repeat (2) send(2, 0, 1200, DP_LUX_COEF);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #2;
        check_reset_outputs("midreset_hold");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) send(2, 0, 2000, DP_LUX_COEF);
        push2(0, 1660, 1'b0);
        send(2, 0, 2000, DP_LUX_COEF);
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
